// File: rtl/down_timer_pkg.sv
// Shared lab definitions for the down_timer slice:
// FSM state encodings and active-low 7-segment patterns.
package down_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Segment order {g,f,e,d,c,b,a}, low = lit.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam logic [7:0] Q_ZERO = 8'h00;
    localparam logic [7:0] Q_ONE  = 8'h01;

endpackage

// File: rtl/down_timer_hex_decoder.sv
// Shared hex-to-7-segment decoder (active-low, 0-F).
// Pure combinational lookup.
module hex_decoder
    import down_timer_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_LUT[i_nibble];

endmodule

// File: rtl/down_timer.sv
// Loadable 8-bit down-counting timer with optional auto-reload,
// expiry pulse and two hex digit outputs.
module down_timer
    import down_timer_pkg::*;
#(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic [7:0] i_load_value,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_enable,
    output logic [7:0] o_q,
    output logic       o_done,
    output logic       o_running,
    output logic       o_expired,
    output logic [6:0] o_hex1,
    output logic [6:0] o_hex0
);

    state_e     r_state;
    logic [7:0] r_q;
    logic [7:0] r_r;
    logic       r_done;

    state_e     w_state_nxt;
    logic [7:0] w_q_nxt;
    logic [7:0] w_r_nxt;
    logic       w_done_nxt;

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_state <= ST_IDLE;
            r_q     <= Q_ZERO;
            r_r     <= Q_ZERO;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_r     <= w_r_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Priority below Clear: Load > Stop > Start > Enable.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_r_nxt     = r_r;
        w_done_nxt  = 1'b0;
        if (i_load) begin
            w_state_nxt = ST_IDLE;
            w_q_nxt     = i_load_value;
            w_r_nxt     = i_load_value;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    if (i_stop) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (i_enable) begin
                        if (r_q > Q_ONE) begin
                            w_q_nxt = r_q - 8'd1;
                        end else if (r_q == Q_ONE) begin
                            w_done_nxt = 1'b1;
                            if (AUTO_RELOAD) begin
                                w_q_nxt = r_r;
                            end else begin
                                w_q_nxt     = Q_ZERO;
                                w_state_nxt = ST_DONE;
                            end
                        end
                    end
                end
                ST_IDLE, ST_PAUSE: begin
                    if (i_start) begin
                        w_state_nxt = (r_q != Q_ZERO) ? ST_RUN : ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_start && r_r != Q_ZERO) begin
                        w_q_nxt     = r_r;
                        w_state_nxt = ST_RUN;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_q       = r_q;
        o_done    = r_done;
        o_running = (r_state == ST_RUN);
        o_expired = (r_state == ST_DONE);
    end

    hex_decoder u_hex1 (
        .i_nibble (r_q[7:4]),
        .o_seg    (o_hex1)
    );

    hex_decoder u_hex0 (
        .i_nibble (r_q[3:0]),
        .o_seg    (o_hex0)
    );

endmodule
